// File: rtl/kiwih_scan_bridge_if.sv
// Tile-pin bundle of the multi-chain scan bridge.
// The master side is the tile and the chains; the slave side is the bridge.
interface kiwih_scan_bridge_if #(
    parameter int NUM_CHAINS = 2
);
    localparam int SEL_W = (NUM_CHAINS > 2) ? $clog2(NUM_CHAINS) : 1;

    logic                  scan_en_n;
    logic                  proc_en_n;
    logic                  scan_in;
    logic                  btn_in;
    logic                  halt_in;
    logic [NUM_CHAINS-1:0] chain_scan_out;
    logic [NUM_CHAINS-1:0] chain_scan_en;
    logic                  chain_scan_in;
    logic                  proc_en;
    logic                  miso;
    logic                  btn_out;
    logic                  frame_done;
    logic                  frame_err;
    logic [SEL_W-1:0]      active_chain;

    modport master (
        output scan_en_n, proc_en_n, scan_in, btn_in, halt_in,
        output chain_scan_out,
        input  chain_scan_en, chain_scan_in, proc_en, miso,
        input  btn_out, frame_done, frame_err, active_chain
    );

    modport slave (
        input  scan_en_n, proc_en_n, scan_in, btn_in, halt_in,
        input  chain_scan_out,
        output chain_scan_en, chain_scan_in, proc_en, miso,
        output btn_out, frame_done, frame_err, active_chain
    );
endinterface

// File: rtl/kiwih_scan_bridge.sv
// Multi-chain scan controller: header-selected chain, length-checked frames,
// processor enable arbitration, MISO mux and button debounce.
module kiwih_scan_bridge #(
    parameter int NUM_CHAINS = 2,
    parameter int CHAIN_LEN  = 152,
    parameter int DEBOUNCE   = 4
) (
    input  logic                clk,
    input  logic                rst,
    kiwih_scan_bridge_if.slave  bus
);
    localparam int SEL_W = (NUM_CHAINS > 2) ? $clog2(NUM_CHAINS) : 1;
    localparam int HCW   = $clog2(SEL_W + 1);
    localparam int BCW   = $clog2(CHAIN_LEN + 1);
    localparam int DCW   = $clog2(DEBOUNCE + 1);

    typedef enum logic [1:0] {IDLE, HDR, SHIFT, DONE} state_e;

    state_e           state_q, state_d;
    logic [SEL_W-1:0] hdr_q, hdr_d;
    logic [HCW-1:0]   hdr_cnt_q, hdr_cnt_d;
    logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [SEL_W-1:0] active_chain_q, active_chain_d;
    logic             frame_done_q, frame_done_d;
    logic             frame_err_q, frame_err_d;
    logic             ovr_q, ovr_d;
    logic             hdr_err_q, hdr_err_d;
    logic [1:0]       btn_sync_q, btn_sync_d;
    logic [DCW-1:0]   dcnt_q, dcnt_d;
    logic             btn_out_q, btn_out_d;

    logic [SEL_W-1:0] hdr_base;
    logic [SEL_W-1:0] hdr_new;
    logic [HCW-1:0]   hcnt_new;
    logic             hdr_ok;
    logic             proc_en_c;
    logic             miso_c;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            hdr_q          <= '0;
            hdr_cnt_q      <= '0;
            bit_cnt_q      <= '0;
            active_chain_q <= '0;
            frame_done_q   <= 1'b0;
            frame_err_q    <= 1'b0;
            ovr_q          <= 1'b0;
            hdr_err_q      <= 1'b0;
            btn_sync_q     <= '0;
            dcnt_q         <= '0;
            btn_out_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            hdr_q          <= hdr_d;
            hdr_cnt_q      <= hdr_cnt_d;
            bit_cnt_q      <= bit_cnt_d;
            active_chain_q <= active_chain_d;
            frame_done_q   <= frame_done_d;
            frame_err_q    <= frame_err_d;
            ovr_q          <= ovr_d;
            hdr_err_q      <= hdr_err_d;
            btn_sync_q     <= btn_sync_d;
            dcnt_q         <= dcnt_d;
            btn_out_q      <= btn_out_d;
        end
    end

    // Header shifts in MSB first; a fresh frame starts from an empty header.
    always_comb begin
        hdr_base = (state_q == IDLE) ? {SEL_W{1'b0}} : hdr_q;
        hdr_new  = SEL_W'({hdr_base, bus.scan_in});
        hcnt_new = (state_q == IDLE) ? HCW'(1) : hdr_cnt_q + HCW'(1);
        hdr_ok   = 32'(hdr_new) < NUM_CHAINS;
    end

    always_comb begin
        state_d        = state_q;
        hdr_d          = hdr_q;
        hdr_cnt_d      = hdr_cnt_q;
        bit_cnt_d      = bit_cnt_q;
        active_chain_d = active_chain_q;
        frame_done_d   = 1'b0;
        frame_err_d    = frame_err_q;
        ovr_d          = ovr_q;
        hdr_err_d      = hdr_err_q;
        unique case (state_q)
            IDLE, HDR: begin
                if (bus.scan_en_n) begin
                    if (state_q == HDR) begin
                        frame_err_d = 1'b1;
                        state_d     = IDLE;
                    end
                end else begin
                    hdr_d     = hdr_new;
                    hdr_cnt_d = hcnt_new;
                    if (state_q == IDLE) begin
                        ovr_d     = 1'b0;
                        hdr_err_d = 1'b0;
                        bit_cnt_d = '0;
                    end
                    if (hcnt_new == HCW'(SEL_W)) begin
                        if (hdr_ok) begin
                            active_chain_d = hdr_new;
                            bit_cnt_d      = '0;
                            state_d        = SHIFT;
                        end else begin
                            hdr_err_d   = 1'b1;
                            frame_err_d = 1'b1;
                            state_d     = DONE;
                        end
                    end else begin
                        state_d = HDR;
                    end
                end
            end
            SHIFT: begin
                if (bus.scan_en_n) begin
                    frame_err_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    bit_cnt_d = bit_cnt_q + BCW'(1);
                    if (bit_cnt_d == BCW'(CHAIN_LEN)) state_d = DONE;
                end
            end
            DONE: begin
                if (bus.scan_en_n) begin
                    state_d = IDLE;
                    if (bit_cnt_q == BCW'(CHAIN_LEN) && !ovr_q && !hdr_err_q) begin
                        frame_done_d = 1'b1;
                        frame_err_d  = 1'b0;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    ovr_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        btn_sync_d = {btn_sync_q[0], bus.btn_in};
        btn_out_d  = btn_out_q;
        dcnt_d     = '0;
        if (btn_sync_q[1] != btn_out_q) begin
            dcnt_d = dcnt_q + DCW'(1);
            if (dcnt_d == DCW'(DEBOUNCE)) begin
                btn_out_d = ~btn_out_q;
                dcnt_d    = '0;
            end
        end
    end

    // Pass-through pins are gated so every output is low during reset.
    always_comb begin
        proc_en_c = rst && !bus.proc_en_n && (state_q == IDLE) && bus.scan_en_n;
        miso_c    = 1'b0;
        if (rst && !bus.scan_en_n && (state_q == SHIFT || state_q == DONE))
            miso_c = bus.chain_scan_out[active_chain_q];
        else if (proc_en_c)
            miso_c = bus.halt_in;
    end

    assign bus.chain_scan_en = (rst && state_q == SHIFT && !bus.scan_en_n)
                             ? (NUM_CHAINS'(1) << active_chain_q)
                             : '0;
    assign bus.chain_scan_in = rst & bus.scan_in;
    assign bus.proc_en       = proc_en_c;
    assign bus.miso          = miso_c;
    assign bus.btn_out       = btn_out_q;
    assign bus.frame_done    = frame_done_q;
    assign bus.frame_err     = frame_err_q;
    assign bus.active_chain  = active_chain_q;
endmodule
